// File: rtl/el2_lsu_dccm_mem_mp.sv
// el2_lsu_dccm_mem_mp
//
// Banked DCCM wrapper with one write port and one read port that both
// operate in the same cycle. Each access is split into lo/hi halves so a
// misaligned transfer can touch two adjacent banks. A read that needs a bank
// the write is also using is stalled through rd_ready. Read data returns
// after RD_LAT cycles (1 or 2) together with its tag. A saturating counter
// records the cycles in which a read was stalled.
//
// Optional feature macro: DCCM_WR_FWD_EN
//   When defined, a read whose overlapping banks all hit the same index as
//   the concurrent write is accepted. The RAM read for those banks is
//   skipped and the write data is forwarded instead. An overlap at a
//   different index still stalls. When undefined, any bank overlap stalls.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clk_override              forces every bank enable high
//   wr_valid                  write request (never stalled)
//   wr_addr_lo/hi             write byte address, lo/hi half
//   wr_data_lo/hi             write bank word, lo/hi half
//   rd_valid, rd_ready        read request / accepted this cycle
//   rd_addr_lo/hi, rd_tag     read byte address halves and tag
//   rd_data_valid             returning read data valid
//   rd_data_lo/hi, rd_tag_out returned words and tag (held when not valid)
//   conflict_cnt              saturating count of stalled read cycles

module el2_lsu_dccm_mem_mp #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 39,
    parameter int BYTE_WIDTH = 4,
    parameter int ADDR_BITS  = 16,
    parameter int RD_LAT     = 1,
    parameter int TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_override,
    input  logic                  wr_valid,
    input  logic [ADDR_BITS-1:0]  wr_addr_lo,
    input  logic [ADDR_BITS-1:0]  wr_addr_hi,
    input  logic [DATA_WIDTH-1:0] wr_data_lo,
    input  logic [DATA_WIDTH-1:0] wr_data_hi,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_BITS-1:0]  rd_addr_lo,
    input  logic [ADDR_BITS-1:0]  rd_addr_hi,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data_lo,
    output logic [DATA_WIDTH-1:0] rd_data_hi,
    output logic [TAG_W-1:0]      rd_tag_out,
    output logic [15:0]           conflict_cnt
);

    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int WB         = $clog2(BYTE_WIDTH);
    localparam int INDEX_BITS = ADDR_BITS - BANK_BITS - WB;
    localparam int DEPTH      = 1 << INDEX_BITS;

    typedef logic [BANK_BITS-1:0]  bank_t;
    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    bank_t wr_bank_lo, wr_bank_hi, rd_bank_lo, rd_bank_hi;
    idx_t  wr_idx_lo, wr_idx_hi, rd_idx_lo, rd_idx_hi;
    logic  wr_unaligned, rd_unaligned, wr_go;

    assign wr_bank_lo = wr_addr_lo[WB +: BANK_BITS];
    assign wr_bank_hi = wr_addr_hi[WB +: BANK_BITS];
    assign rd_bank_lo = rd_addr_lo[WB +: BANK_BITS];
    assign rd_bank_hi = rd_addr_hi[WB +: BANK_BITS];
    assign wr_idx_lo  = wr_addr_lo[ADDR_BITS-1:WB+BANK_BITS];
    assign wr_idx_hi  = wr_addr_hi[ADDR_BITS-1:WB+BANK_BITS];
    assign rd_idx_lo  = rd_addr_lo[ADDR_BITS-1:WB+BANK_BITS];
    assign rd_idx_hi  = rd_addr_hi[ADDR_BITS-1:WB+BANK_BITS];

    // Byte-within-word bits do not affect bank selection.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{wr_addr_lo[WB-1:0], wr_addr_hi[WB-1:0],
                                rd_addr_lo[WB-1:0], rd_addr_hi[WB-1:0]};

    assign wr_unaligned = (wr_bank_lo != wr_bank_hi);
    assign rd_unaligned = (rd_bank_lo != rd_bank_hi);
    // A write presented while in reset is dropped.
    assign wr_go        = wr_valid & ~rst;

    // Per-bank view of both ports: which bank each half lands in, and the
    // index/data that bank sees. The lo half owns a bank when both map to it.
    logic [NUM_BANKS-1:0] wr_touch, rd_touch, overlap;
    idx_t                 wr_idx_bank [NUM_BANKS];
    idx_t                 rd_idx_bank [NUM_BANKS];
    word_t                wr_data_bank[NUM_BANKS];

    always_comb begin
        wr_touch     = '0;
        rd_touch     = '0;
        wr_idx_bank  = '{default: '0};
        rd_idx_bank  = '{default: '0};
        wr_data_bank = '{default: '0};
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_bank_lo == bank_t'(b)) begin
                wr_idx_bank[b]  = wr_idx_lo;
                wr_data_bank[b] = wr_data_lo;
                wr_touch[b]     = wr_go;
            end else begin
                wr_idx_bank[b]  = wr_idx_hi;
                wr_data_bank[b] = wr_data_hi;
                wr_touch[b]     = wr_go & wr_unaligned & (wr_bank_hi == bank_t'(b));
            end
            if (rd_bank_lo == bank_t'(b)) begin
                rd_idx_bank[b] = rd_idx_lo;
                rd_touch[b]    = rd_valid;
            end else begin
                rd_idx_bank[b] = rd_idx_hi;
                rd_touch[b]    = rd_valid & rd_unaligned & (rd_bank_hi == bank_t'(b));
            end
        end
    end

    assign overlap = wr_touch & rd_touch;

    logic                 no_stall;
    logic [NUM_BANKS-1:0] fwd_bank;

`ifdef DCCM_WR_FWD_EN
    // An overlap is harmless when both ports address the same word: the
    // read simply takes the data being written this cycle.
    logic [NUM_BANKS-1:0] idx_clash;
    always_comb begin
        idx_clash = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            idx_clash[b] = overlap[b] & (wr_idx_bank[b] != rd_idx_bank[b]);
        end
    end
    assign no_stall = (idx_clash == '0);
    assign fwd_bank = overlap;
`else
    assign no_stall = (overlap == '0);
    assign fwd_bank = '0;
`endif

    logic                 rd_accept;
    logic [NUM_BANKS-1:0] rd_acc_touch, bank_en;

    assign rd_ready     = ~rst & no_stall;
    assign rd_accept    = rd_valid & rd_ready;
    assign rd_acc_touch = rd_touch & {NUM_BANKS{rd_accept}};
    assign bank_en      = wr_touch | rd_acc_touch | {NUM_BANKS{clk_override}};

    // ---- stage p0 -> p1: bank RAM write and synchronous read ----
    word_t mem  [NUM_BANKS][DEPTH];
    word_t dout [NUM_BANKS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b] && wr_touch[b]) begin
                mem[b][wr_idx_bank[b]] <= wr_data_bank[b];
            end
        end
    end

    // Read registers only load on an accepted read, so the returned data
    // holds naturally between reads.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rst) begin
                dout[b] <= '0;
            end else if (bank_en[b] && rd_acc_touch[b]) begin
                dout[b] <= fwd_bank[b] ? wr_data_bank[b] : mem[b][rd_idx_bank[b]];
            end
        end
    end

    logic             vld_p1;
    bank_t            sel_lo_p1, sel_hi_p1;
    logic [TAG_W-1:0] tag_p1;
    word_t            data_lo_p1, data_hi_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            sel_lo_p1 <= '0;
            sel_hi_p1 <= '0;
            tag_p1    <= '0;
        end else begin
            vld_p1 <= rd_accept;
            if (rd_accept) begin
                sel_lo_p1 <= rd_bank_lo;
                // Aligned reads mirror the lo word onto the hi half.
                sel_hi_p1 <= rd_unaligned ? rd_bank_hi : rd_bank_lo;
                tag_p1    <= rd_tag;
            end
        end
    end

    assign data_lo_p1 = dout[sel_lo_p1];
    assign data_hi_p1 = dout[sel_hi_p1];

    generate
        if (RD_LAT == 2) begin : g_lat2
            // ---- stage p1 -> p2: extra output register ----
            logic             vld_p2;
            word_t            data_lo_p2, data_hi_p2;
            logic [TAG_W-1:0] tag_p2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p2     <= 1'b0;
                    data_lo_p2 <= '0;
                    data_hi_p2 <= '0;
                    tag_p2     <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        data_lo_p2 <= data_lo_p1;
                        data_hi_p2 <= data_hi_p1;
                        tag_p2     <= tag_p1;
                    end
                end
            end

            assign rd_data_valid = vld_p2;
            assign rd_data_lo    = data_lo_p2;
            assign rd_data_hi    = data_hi_p2;
            assign rd_tag_out    = tag_p2;
        end else begin : g_lat1
            assign rd_data_valid = vld_p1;
            assign rd_data_lo    = data_lo_p1;
            assign rd_data_hi    = data_hi_p1;
            assign rd_tag_out    = tag_p1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (rd_valid && !rd_ready) begin
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: tb/tb_el2_lsu_dccm_mem_mp.sv
module tb_el2_lsu_dccm_mem_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_override = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr_lo = '0, wr_addr_hi = '0;
    logic [38:0] wr_data_lo = '0, wr_data_hi = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_addr_lo = '0, rd_addr_hi = '0;
    logic [3:0]  rd_tag = '0;

    logic        rdy1, rdy2, v1, v2;
    logic [38:0] lo1, hi1, lo2, hi2;
    logic [3:0]  tag1, tag2;
    logic [15:0] cnt1, cnt2;

    always #5 clk = ~clk;

    el2_lsu_dccm_mem_mp #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .clk_override(clk_override),
        .wr_valid(wr_valid), .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi),
        .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
        .rd_valid(rd_valid), .rd_ready(rdy1), .rd_addr_lo(rd_addr_lo),
        .rd_addr_hi(rd_addr_hi), .rd_tag(rd_tag), .rd_data_valid(v1),
        .rd_data_lo(lo1), .rd_data_hi(hi1), .rd_tag_out(tag1), .conflict_cnt(cnt1)
    );

    el2_lsu_dccm_mem_mp #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .clk_override(clk_override),
        .wr_valid(wr_valid), .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi),
        .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
        .rd_valid(rd_valid), .rd_ready(rdy2), .rd_addr_lo(rd_addr_lo),
        .rd_addr_hi(rd_addr_hi), .rd_tag(rd_tag), .rd_data_valid(v2),
        .rd_data_lo(lo2), .rd_data_hi(hi2), .rd_tag_out(tag2), .conflict_cnt(cnt2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: word memory keyed by bank*4096+index, expected output
    // state of the 1-cycle and 2-cycle instances, and the stall counter.
    logic [38:0] mref [int];
    bit          exp_ready, obs_rdy1, obs_rdy2;
    int          exp_cnt = 0;
    bit          e1_v = 0, e2_v = 0, q_v = 0;
    logic [38:0] e1_lo = '0, e1_hi = '0, e2_lo = '0, e2_hi = '0, q_lo = '0, q_hi = '0;
    logic [3:0]  e1_tag = '0, e2_tag = '0, q_tag = '0;

    function automatic int bank_of(logic [15:0] a);
        return int'((a >> 2) & 16'd3);
    endfunction
    function automatic int idx_of(logic [15:0] a);
        return int'(a >> 4);
    endfunction
    function automatic int key_of(logic [15:0] a);
        return bank_of(a) * 4096 + idx_of(a);
    endfunction
    function automatic logic [38:0] mem_rd(int k);
        if (mref.exists(k)) return mref[k];
        return '0;
    endfunction
    function automatic logic [38:0] wdata_for(int b);
        return (bank_of(wr_addr_lo) == b) ? wr_data_lo : wr_data_hi;
    endfunction
    function automatic int widx_for(int b);
        return (bank_of(wr_addr_lo) == b) ? idx_of(wr_addr_lo) : idx_of(wr_addr_hi);
    endfunction
    function automatic int ridx_for(int b);
        return (bank_of(rd_addr_lo) == b) ? idx_of(rd_addr_lo) : idx_of(rd_addr_hi);
    endfunction

    // Advance one clock: predict this cycle from the current inputs, sample
    // rd_ready mid-cycle, then update the model at the edge.
    task automatic tick();
        int wmask, rmask, ov, bl, bh;
        bit acc;
        logic [38:0] dlo, dhi;
        wmask = 0;
        rmask = 0;
        if (wr_valid && !rst) wmask = (1 << bank_of(wr_addr_lo)) | (1 << bank_of(wr_addr_hi));
        if (rd_valid) rmask = (1 << bank_of(rd_addr_lo)) | (1 << bank_of(rd_addr_hi));
        ov = wmask & rmask;
`ifdef DCCM_WR_FWD_EN
        exp_ready = !rst;
        for (int b = 0; b < 4; b++)
            if (((ov >> b) & 1) == 1 && widx_for(b) != ridx_for(b)) exp_ready = 0;
`else
        exp_ready = !rst && (ov == 0);
`endif
        acc = rd_valid && exp_ready;
        bl  = bank_of(rd_addr_lo);
        bh  = bank_of(rd_addr_hi);
        dlo = (((ov >> bl) & 1) == 1) ? wdata_for(bl) : mem_rd(key_of(rd_addr_lo));
        if (bl == bh) dhi = dlo;
        else dhi = (((ov >> bh) & 1) == 1) ? wdata_for(bh) : mem_rd(key_of(rd_addr_hi));

        @(negedge clk);
        obs_rdy1 = rdy1;
        obs_rdy2 = rdy2;
        @(posedge clk);

        if (rst) exp_cnt = 0;
        else if (rd_valid && !exp_ready && exp_cnt < 65535) exp_cnt++;
        if (wr_valid && !rst) begin
            mref[key_of(wr_addr_lo)] = wr_data_lo;
            if (bank_of(wr_addr_lo) != bank_of(wr_addr_hi)) mref[key_of(wr_addr_hi)] = wr_data_hi;
        end
        if (rst) begin
            e1_v = 0; e1_lo = '0; e1_hi = '0; e1_tag = '0;
            e2_v = 0; e2_lo = '0; e2_hi = '0; e2_tag = '0;
            q_v  = 0;
        end else begin
            e2_v = q_v;
            if (q_v) begin e2_lo = q_lo; e2_hi = q_hi; e2_tag = q_tag; end
            q_v  = acc;
            e1_v = acc;
            if (acc) begin
                q_lo = dlo;  q_hi = dhi;  q_tag = rd_tag;
                e1_lo = dlo; e1_hi = dhi; e1_tag = rd_tag;
            end
        end
        #1;
    endtask

    task automatic idle();
        wr_valid = 0;
        rd_valid = 0;
    endtask

    task automatic set_wr(logic [15:0] alo, logic [15:0] ahi, logic [38:0] dlo, logic [38:0] dhi);
        wr_valid = 1; wr_addr_lo = alo; wr_addr_hi = ahi; wr_data_lo = dlo; wr_data_hi = dhi;
    endtask

    task automatic set_rd(logic [15:0] alo, logic [15:0] ahi, logic [3:0] tag);
        rd_valid = 1; rd_addr_lo = alo; rd_addr_hi = ahi; rd_tag = tag;
    endtask

    task automatic test_reset();
        rst = 1;
        set_rd(16'h0010, 16'h0010, 4'h1);
        tick();
        tick();
        total++; if (obs_rdy1 !== 1'b0 || obs_rdy2 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b%b want 00", obs_rdy1, obs_rdy2); end
        total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b%b want 00", v1, v2); end
        total++; if ({lo1, hi1, lo2, hi2} !== '0) begin bad++; $display("FAIL reset_data: got %h %h %h %h want 0", lo1, hi1, lo2, hi2); end
        total++; if ({tag1, tag2} !== 8'h00) begin bad++; $display("FAIL reset_tag: got %h %h want 0", tag1, tag2); end
        total++; if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d %0d want 0", cnt1, cnt2); end
        idle();
        rst = 0;
    endtask

    task automatic test_init();
        for (int a = 0; a < 256; a += 8) begin
            set_wr(16'(a), 16'(a + 4), 39'({$urandom, $urandom}), 39'({$urandom, $urandom}));
            tick();
        end
        idle();
        total++; if (obs_rdy1 !== 1'b1) begin bad++; $display("FAIL init_ready: got %b want 1", obs_rdy1); end
    endtask

    task automatic test_basic();
        set_wr(16'h0010, 16'h0010, 39'h12345678, 39'h7777);
        tick();
        idle();
        set_rd(16'h0010, 16'h0010, 4'h3);
        tick();
        total++; if (obs_rdy1 !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", obs_rdy1); end
        total++; if ({v1, lo1, hi1, tag1} !== {1'b1, 39'h12345678, 39'h12345678, 4'h3})
            begin bad++; $display("FAIL basic_lat1: got v=%b %h %h t=%h want v=1 12345678 12345678 t=3", v1, lo1, hi1, tag1); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL basic_lat2_early: got %b want 0", v2); end
        idle();
        tick();
        total++; if ({v2, lo2, tag2} !== {1'b1, 39'h12345678, 4'h3})
            begin bad++; $display("FAIL basic_lat2: got v=%b %h t=%h want v=1 12345678 t=3", v2, lo2, tag2); end
        total++; if ({v1, lo1, tag1} !== {1'b0, 39'h12345678, 4'h3})
            begin bad++; $display("FAIL basic_hold: got v=%b %h t=%h want v=0 12345678 t=3", v1, lo1, tag1); end
    endtask

    task automatic test_unaligned();
        set_wr(16'h001C, 16'h0020, 39'hA, 39'hB);
        tick();
        idle();
        set_rd(16'h001C, 16'h0020, 4'h7);
        tick();
        idle();
        total++; if ({v1, lo1, hi1, tag1} !== {1'b1, 39'hA, 39'hB, 4'h7})
            begin bad++; $display("FAIL unal_lat1: got v=%b %h %h t=%h want v=1 a b t=7", v1, lo1, hi1, tag1); end
        tick();
        total++; if ({v2, lo2, hi2, tag2} !== {1'b1, 39'hA, 39'hB, 4'h7})
            begin bad++; $display("FAIL unal_lat2: got v=%b %h %h t=%h want v=1 a b t=7", v2, lo2, hi2, tag2); end
    endtask

    task automatic test_conflict();
        set_wr(16'h0040, 16'h0040, 39'h4444, 39'h0);
        set_rd(16'h0080, 16'h0080, 4'h5);
        tick();
        total++; if (obs_rdy1 !== 1'b0 || obs_rdy2 !== 1'b0) begin bad++; $display("FAIL conflict_ready: got %b%b want 00", obs_rdy1, obs_rdy2); end
        total++; if (cnt1 !== 16'd1 || cnt2 !== 16'd1) begin bad++; $display("FAIL conflict_cnt: got %0d %0d want 1", cnt1, cnt2); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL conflict_novalid: got %b want 0", v1); end
        wr_valid = 0;
        tick();
        total++; if (obs_rdy1 !== 1'b1) begin bad++; $display("FAIL conflict_retry_ready: got %b want 1", obs_rdy1); end
        total++; if ({v1, lo1, tag1} !== {1'b1, mref[key_of(16'h0080)], 4'h5})
            begin bad++; $display("FAIL conflict_retry_data: got v=%b %h t=%h want v=1 %h t=5", v1, lo1, tag1, mref[key_of(16'h0080)]); end
        total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL conflict_cnt_hold: got %0d want 1", cnt1); end
        // Write on banks {3,0} and read on banks {1,2} coexist.
        set_wr(16'h002C, 16'h0030, 39'h3C3C, 39'h3030);
        set_rd(16'h0024, 16'h0028, 4'hC);
        tick();
        idle();
        total++; if (obs_rdy1 !== 1'b1) begin bad++; $display("FAIL disjoint_ready: got %b want 1", obs_rdy1); end
        total++; if ({lo1, hi1} !== {mref[key_of(16'h0024)], mref[key_of(16'h0028)]})
            begin bad++; $display("FAIL disjoint_data: got %h %h want %h %h", lo1, hi1, mref[key_of(16'h0024)], mref[key_of(16'h0028)]); end
        total++; if (mref[key_of(16'h002C)] !== 39'h3C3C) begin bad++; $display("FAIL disjoint_model: got %h want 3c3c", mref[key_of(16'h002C)]); end
        tick();
    endtask

    task automatic test_fwd();
        set_wr(16'h0040, 16'h0040, 39'h55, 39'h0);
        set_rd(16'h0040, 16'h0040, 4'h9);
        tick();
`ifdef DCCM_WR_FWD_EN
        total++; if (obs_rdy1 !== 1'b1) begin bad++; $display("FAIL fwd_ready: got %b want 1", obs_rdy1); end
`else
        total++; if (obs_rdy1 !== 1'b0) begin bad++; $display("FAIL fwd_stall: got %b want 0", obs_rdy1); end
        total++; if (cnt1 !== 16'd2) begin bad++; $display("FAIL fwd_cnt: got %0d want 2", cnt1); end
        wr_valid = 0;
        tick();
`endif
        idle();
        total++; if ({v1, lo1, tag1} !== {1'b1, 39'h55, 4'h9})
            begin bad++; $display("FAIL fwd_data: got v=%b %h t=%h want v=1 55 t=9", v1, lo1, tag1); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 60) * 4);
            set_rd(a, (i % 2 == 0) ? a : a + 16'd4, 4'(i));
            tick();
            total++; if ({v1, lo1, hi1, tag1} !== {1'b1, e1_lo, e1_hi, 4'(i)})
                begin bad++; $display("FAIL b2b_lat1_%0d: got v=%b %h %h t=%h want v=1 %h %h t=%h", i, v1, lo1, hi1, tag1, e1_lo, e1_hi, 4'(i)); end
            if (i > 0) begin
                total++; if ({v2, tag2} !== {1'b1, 4'(i - 1)})
                    begin bad++; $display("FAIL b2b_lat2_%0d: got v=%b t=%h want v=1 t=%h", i, v2, tag2, 4'(i - 1)); end
            end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            logic [15:0] a, b;
            rst          = ($urandom_range(0, 49) == 0);
            clk_override = $urandom_range(0, 3) == 0;
            wr_valid     = $urandom_range(0, 1);
            a            = 16'($urandom_range(0, 31) * 4);
            wr_addr_lo   = a;
            wr_addr_hi   = $urandom_range(0, 1) ? a : a + 16'd4;
            wr_data_lo   = 39'({$urandom, $urandom});
            wr_data_hi   = 39'({$urandom, $urandom});
            rd_valid     = $urandom_range(0, 9) < 7;
            b            = 16'($urandom_range(0, 31) * 4);
            rd_addr_lo   = b;
            rd_addr_hi   = $urandom_range(0, 1) ? b : b + 16'd4;
            rd_tag       = 4'($urandom);
            tick();
            total++; if (obs_rdy1 !== exp_ready || obs_rdy2 !== exp_ready)
                begin bad++; $display("FAIL rnd_ready_%0d: got %b%b want %b", i, obs_rdy1, obs_rdy2, exp_ready); end
            total++; if ({v1, lo1, hi1, tag1} !== {e1_v, e1_lo, e1_hi, e1_tag})
                begin bad++; $display("FAIL rnd_lat1_%0d: got v=%b %h %h t=%h want v=%b %h %h t=%h", i, v1, lo1, hi1, tag1, e1_v, e1_lo, e1_hi, e1_tag); end
            total++; if ({v2, lo2, hi2, tag2} !== {e2_v, e2_lo, e2_hi, e2_tag})
                begin bad++; $display("FAIL rnd_lat2_%0d: got v=%b %h %h t=%h want v=%b %h %h t=%h", i, v2, lo2, hi2, tag2, e2_v, e2_lo, e2_hi, e2_tag); end
            total++; if (cnt1 !== 16'(exp_cnt) || cnt2 !== 16'(exp_cnt))
                begin bad++; $display("FAIL rnd_cnt_%0d: got %0d %0d want %0d", i, cnt1, cnt2, exp_cnt); end
        end
        rst = 0;
        clk_override = 0;
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [38:0] keep;
        keep = mref[key_of(16'h0010)];
        set_rd(16'h0010, 16'h0010, 4'h6);
        tick();
        total++; if (obs_rdy2 !== 1'b1) begin bad++; $display("FAIL mid_accept: got %b want 1", obs_rdy2); end
        idle();
        rst = 1;
        set_wr(16'h0010, 16'h0010, 39'h777, 39'h777);
        tick();
        total++; if (v2 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b%b want 00", v1, v2); end
        total++; if (cnt2 !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt2); end
        rst = 0;
        idle();
        set_rd(16'h0010, 16'h0010, 4'hE);
        tick();
        idle();
        total++; if (obs_rdy2 !== 1'b1) begin bad++; $display("FAIL mid_first_accept: got %b want 1", obs_rdy2); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL mid_discard: got %b want 0", v2); end
        tick();
        total++; if ({v2, lo2, tag2} !== {1'b1, keep, 4'hE})
            begin bad++; $display("FAIL mid_no_write: got v=%b %h t=%h want v=1 %h t=e", v2, lo2, tag2, keep); end
        tick();
    endtask

    task automatic test_saturation();
        set_wr(16'h0040, 16'h0040, 39'h1, 39'h1);
        set_rd(16'h0080, 16'h0080, 4'h2);
        for (int i = 0; i < 65540; i++) tick();
        total++; if (cnt1 !== 16'hFFFF || cnt2 !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt: got %h %h want ffff", cnt1, cnt2); end
        total++; if (obs_rdy1 !== 1'b0) begin bad++; $display("FAIL sat_ready: got %b want 0", obs_rdy1); end
        tick();
        tick();
        total++; if (cnt1 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", cnt1); end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_unaligned();
        test_conflict();
        test_fwd();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
